// File: rtl/alarm_timer_pkg.sv
// Shared types and sizing helpers for the parametrised alarm timer.
// Holds the FSM state enum and the prescaler sizing functions.
package alarm_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Prescaler period: one 2 Hz tick every half-second.
    function automatic int half_of(input int freq);
        return freq / 2;
    endfunction

    // Width of the prescaler counter, never below one bit.
    function automatic int div_width(input int freq);
        int h;
        h = freq / 2;
        return (h <= 2) ? 1 : $clog2(h);
    endfunction

endpackage

// File: rtl/alarm_timer_prescaler.sv
// Half-second prescaler: produces tick2 (2 Hz) and tick1 (1 Hz).
// Ports: clock, reset, clear (restart at 0), hold (freeze), tick1, tick2.
module alarm_timer_prescaler
    import alarm_timer_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tick1,
    output logic tick2
);

    localparam int HALF  = half_of(CLK_FREQ_HZ);
    localparam int DIV_W = div_width(CLK_FREQ_HZ);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(HALF - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_phase;
    logic             w_wrap;

    assign w_wrap = (r_div == LAST);
    // A clear restarts the second, so no tick may escape on that edge.
    assign tick2  = w_wrap && !clear && !hold;
    assign tick1  = tick2 && r_phase;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_div   <= '0;
            r_phase <= 1'b0;
        end else if (!hold) begin
            if (w_wrap) begin
                r_div   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_div   <= r_div + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/alarm_timer_param.sv
// Programmable seconds countdown with pause, auto-reload and busy flag.
// Ports: clock, reset, start_timer, value, periodic, pause in;
//        expired, busy, one_hz_enable, two_hz_enable, counter out.
module alarm_timer_param
    import alarm_timer_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int VALUE_W     = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_timer,
    input  logic [VALUE_W-1:0] value,
    input  logic               periodic,
    input  logic               pause,
    output logic               expired,
    output logic               busy,
    output logic               one_hz_enable,
    output logic               two_hz_enable,
    output logic [VALUE_W-1:0] counter
);

    state_t             r_state;
    logic [VALUE_W-1:0] r_counter;
    logic [VALUE_W-1:0] r_reload;
    logic               r_mode;
    logic               r_expired;
    logic               r_busy;
    logic               r_one;
    logic               r_two;

    logic w_tick1;
    logic w_tick2;
    logic w_hold;

    // Pause only matters while a countdown is active.
    assign w_hold = pause && !start_timer &&
                    (r_state == ST_RUN || r_state == ST_PAUSED);

    alarm_timer_prescaler #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_presc (
        .clock(clock),
        .reset(reset),
        .clear(start_timer),
        .hold (w_hold),
        .tick1(w_tick1),
        .tick2(w_tick2)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_counter <= '0;
            r_reload  <= '0;
            r_mode    <= 1'b0;
            r_expired <= 1'b0;
            r_busy    <= 1'b0;
            r_one     <= 1'b0;
            r_two     <= 1'b0;
        end else begin
            r_one <= w_tick1;
            r_two <= w_tick2;
            if (start_timer) begin
                r_reload  <= value;
                r_mode    <= periodic;
                r_counter <= value;
                if (value == '0) begin
                    r_state   <= ST_DONE;
                    r_expired <= 1'b1;
                    r_busy    <= 1'b0;
                end else begin
                    r_state   <= ST_RUN;
                    r_expired <= 1'b0;
                    r_busy    <= 1'b1;
                end
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        r_expired <= 1'b0;
                    end
                    ST_RUN, ST_PAUSED: begin
                        r_expired <= 1'b0;
                        if (pause) begin
                            r_state <= ST_PAUSED;
                        end else begin
                            r_state <= ST_RUN;
                            // Counter is never 0 here: a 0 load goes to DONE.
                            if (w_tick1) begin
                                if (r_counter > VALUE_W'(1)) begin
                                    r_counter <= r_counter - VALUE_W'(1);
                                end else if (r_mode) begin
                                    r_counter <= r_reload;
                                    r_expired <= 1'b1;
                                end else begin
                                    r_counter <= '0;
                                    r_expired <= 1'b1;
                                    r_state   <= ST_DONE;
                                    r_busy    <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_DONE: begin
                        r_expired <= 1'b1;
                        r_counter <= '0;
                    end
                endcase
            end
        end
    end

    assign expired       = r_expired;
    assign busy          = r_busy;
    assign one_hz_enable = r_one;
    assign two_hz_enable = r_two;
    assign counter       = r_counter;

endmodule

// File: tb/tb_alarm_timer_param.sv
// Scoreboard bench for alarm_timer_param at CLK_FREQ_HZ=4, VALUE_W=4.
// Observed vector is {expired, busy, one_hz, two_hz, counter[3:0]}.
module tb_alarm_timer_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_timer;
    logic [3:0] value;
    logic       periodic;
    logic       pause;
    logic       expired;
    logic       busy;
    logic       one_hz_enable;
    logic       two_hz_enable;
    logic [3:0] counter;

    alarm_timer_param #(
        .CLK_FREQ_HZ(4),
        .VALUE_W    (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start_timer  (start_timer),
        .value        (value),
        .periodic     (periodic),
        .pause        (pause),
        .expired      (expired),
        .busy         (busy),
        .one_hz_enable(one_hz_enable),
        .two_hz_enable(two_hz_enable),
        .counter      (counter)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        string      nm;
        logic [7:0] v;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   base;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this sampling point.
    always @(negedge clock) begin
        logic [7:0] obs;
        obs = {expired, busy, one_hz_enable, two_hz_enable, counter};
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_chk++;
            if (e.cyc != cyc)
                $display("FAIL %s cyc %0d: not sampled (now %0d)",
                         e.nm, e.cyc, cyc);
            else if (obs !== e.v)
                $display("FAIL %s cyc %0d: got %b want %b",
                         e.nm, cyc, obs, e.v);
            else
                n_pass++;
        end
    end

    function automatic bit two_at(int k);
        return k > 0 && k % 2 == 0;
    endfunction

    function automatic bit one_at(int k);
        return k > 0 && k % 4 == 0;
    endfunction

    function automatic int os_cnt(int v, int k);
        return (k / 4 >= v) ? 0 : v - k / 4;
    endfunction

    task automatic push(int c, string nm, bit ex, bit bz,
                        bit o, bit t, int cnt);
        exp_t x;
        x.cyc = c;
        x.nm  = nm;
        x.v   = {ex, bz, o, t, 4'(cnt)};
        q.push_back(x);
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_start(int v, bit p);
        start_timer = 1'b1;
        value       = 4'(v);
        periodic    = p;
        base        = cyc + 1;
    endtask

    initial begin
        reset = 1'b1;
        start_timer = 1'b0;
        value = 4'd0;
        periodic = 1'b0;
        pause = 1'b0;

        for (int c = 1; c <= 3; c++) push(c, "reset", 0, 0, 0, 0, 0);
        tick(3);
        reset = 1'b0;
        base = 3;
        for (int k = 1; k <= 8; k++)
            push(base + k, "idle_en", 0, 0, one_at(k), two_at(k), 0);
        tick(8);

        do_start(3, 0);
        for (int k = 0; k <= 32; k++)
            push(base + k, "oneshot3", k >= 12, k < 12,
                 one_at(k), two_at(k), os_cnt(3, k));
        tick(1);
        start_timer = 1'b0;
        tick(32);

        do_start(2, 1);
        for (int k = 0; k <= 26; k++)
            push(base + k, "periodic2", k > 0 && k % 8 == 0, 1,
                 one_at(k), two_at(k), (k % 8 < 4) ? 2 : 1);
        tick(1);
        start_timer = 1'b0;
        tick(26);

        do_start(3, 0);
        for (int k = 0; k <= 20; k++) begin
            int eff;
            bit en;
            en  = (k <= 5 || k >= 11);
            eff = (k <= 5) ? k : (k <= 10 ? 5 : k - 5);
            push(base + k, "pause", eff >= 12, eff < 12,
                 en && one_at(eff), en && two_at(eff), os_cnt(3, eff));
        end
        tick(1);
        start_timer = 1'b0;
        tick(5);
        pause = 1'b1;
        tick(5);
        pause = 1'b0;
        tick(10);

        do_start(5, 0);
        for (int k = 0; k <= 5; k++)
            push(base + k, "val5", 0, 1, one_at(k), two_at(k), os_cnt(5, k));
        tick(1);
        start_timer = 1'b0;
        tick(5);
        do_start(2, 0);
        for (int j = 0; j <= 10; j++)
            push(base + j, "restart2", j >= 8, j < 8,
                 one_at(j), two_at(j), os_cnt(2, j));
        tick(1);
        start_timer = 1'b0;
        tick(10);
        do_start(0, 0);
        for (int j = 0; j <= 4; j++)
            push(base + j, "zero", 1, 0, one_at(j), two_at(j), 0);
        tick(1);
        start_timer = 1'b0;
        tick(4);

        do_start(4, 0);
        for (int k = 0; k <= 6; k++)
            push(base + k, "val4", 0, 1, one_at(k), two_at(k), os_cnt(4, k));
        tick(1);
        start_timer = 1'b0;
        tick(6);
        reset = 1'b1;
        push(base + 7, "midreset", 0, 0, 0, 0, 0);
        tick(1);
        start_timer = 1'b1;
        value = 4'd5;
        push(base + 8, "rst_vs_start", 0, 0, 0, 0, 0);
        tick(1);
        reset = 1'b0;
        start_timer = 1'b0;
        push(base + 9, "post_rst", 0, 0, 0, 0, 0);
        push(base + 10, "post_rst_en", 0, 0, 0, 1, 0);
        tick(2);

        for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
